// File: rtl/apu_audio_pkg.sv
// Shared types, frame constants and the 9-bit unsigned to 16-bit signed sample conversion
// used by the APU I2S output path.
package apu_audio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

  localparam int SLOTS_PER_FRAME = 32;
  localparam int WORD_BITS       = 16;
  localparam int MIDSCALE        = 256;

  // The 9-bit modular difference is already the two's-complement value of (s - MIDSCALE).
  function automatic logic [WORD_BITS-1:0] to_word(input logic [8:0] s, input logic mute);
    logic [8:0] diff;
    diff = s - 9'(MIDSCALE);
    return mute ? '0 : {diff, {(WORD_BITS-9){1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_shifter.sv
// Frame shift register, slot counter and word-select generation for the I2S serializer.
// Everything advances on the bclk falling-edge strobe; latch reloads both words at slot 0.
module i2s_shifter
  import apu_audio_pkg::*;
#(
  parameter int LEFT_JUSTIFY = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 advance,
  input  logic                 latch,
  input  logic [WORD_BITS-1:0] word_l,
  input  logic [WORD_BITS-1:0] word_r,
  output logic [4:0]           slot,
  output logic                 sdata,
  output logic                 lrck
);

  logic [2*WORD_BITS-1:0] sr_q, sr_d;
  logic [4:0]             slot_q, slot_d;
  logic                   sdata_q, sdata_d;
  logic                   lrck_q, lrck_d;

  always_comb begin
    sr_d    = sr_q;
    slot_d  = slot_q;
    sdata_d = sdata_q;
    lrck_d  = lrck_q;
    if (clear) begin
      sr_d    = '0;
      slot_d  = '0;
      sdata_d = 1'b0;
      lrck_d  = 1'b0;
    end else if (advance || latch) begin
      sr_d   = latch ? {word_l, word_r} : {sr_q[2*WORD_BITS-2:0], 1'b0};
      slot_d = latch ? 5'd0 : slot_q + 5'd1;
      // I2S mode emits the pre-shift MSB, giving the one-slot delay (right bit 0 lands in slot 0).
      sdata_d = (LEFT_JUSTIFY != 0) ? sr_d[2*WORD_BITS-1] : sr_q[2*WORD_BITS-1];
      lrck_d  = slot_d[4];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q    <= '0;
      slot_q  <= '0;
      sdata_q <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      slot_q  <= slot_d;
      sdata_q <= sdata_d;
      lrck_q  <= lrck_d;
    end
  end

  assign slot  = slot_q;
  assign sdata = sdata_q;
  assign lrck  = lrck_q;

endmodule

// File: rtl/audio_i2s_out.sv
// APU mix to I2S serializer: IDLE/RUN control, bclk divider, sample conversion and word latch.
// Define AUDIO_I2S_AVG_EN to average each channel over the frame instead of point sampling.
module audio_i2s_out
  import apu_audio_pkg::*;
#(
  parameter int BCLK_HALF    = 8,
  parameter int LEFT_JUSTIFY = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       mute,
  input  logic [8:0] sound_l,
  input  logic [8:0] sound_r,
  output logic       i2s_bclk,
  output logic       i2s_lrck,
  output logic       i2s_sdata,
  output logic       sample_strobe
);

  localparam int DIV_W = $clog2(BCLK_HALF);

  i2s_state_e           state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 bclk_q, bclk_d;
  logic                 strobe_q, strobe_d;
  logic                 latch, clear, fall;
  logic [4:0]           slot;
  logic [8:0]           s_l, s_r;
  logic [WORD_BITS-1:0] word_l, word_r;

  // BCLK_HALF is a power of two, so the all-ones count marks the end of a half period.
  assign fall = (state_q == RUN) && bclk_q && (div_q == {DIV_W{1'b1}});

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bclk_d  = bclk_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        div_d  = '0;
        bclk_d = 1'b0;
        if (enable) begin
          state_d = RUN;
          latch   = 1'b1;
        end
      end
      RUN: begin
        div_d = div_q + DIV_W'(1);
        if (div_q == {DIV_W{1'b1}}) bclk_d = ~bclk_q;
        if (fall && slot == 5'(SLOTS_PER_FRAME - 1)) begin
          if (enable) begin
            latch = 1'b1;
          end else begin
            state_d = IDLE;
            div_d   = '0;
            bclk_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    strobe_d = latch;
    clear    = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bclk_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef AUDIO_I2S_AVG_EN
  localparam int AVG_SHIFT = 6 + $clog2(BCLK_HALF);
  localparam int ACC_W     = 9 + AVG_SHIFT;

  logic [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d, sum_l, sum_r;

  // The sum includes the latch clk itself, so one frame contributes exactly 64*BCLK_HALF samples.
  always_comb begin
    sum_l   = acc_l_q + ACC_W'(sound_l);
    sum_r   = acc_r_q + ACC_W'(sound_r);
    s_l     = sum_l[AVG_SHIFT +: 9];
    s_r     = sum_r[AVG_SHIFT +: 9];
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    if (latch || clear) begin
      acc_l_d = '0;
      acc_r_d = '0;
    end else if (state_q == RUN) begin
      acc_l_d = sum_l;
      acc_r_d = sum_r;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
    end else begin
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
    end
  end
`else
  assign s_l = sound_l;
  assign s_r = sound_r;
`endif

  assign word_l = to_word(s_l, mute);
  assign word_r = to_word(s_r, mute);

  i2s_shifter #(
    .LEFT_JUSTIFY(LEFT_JUSTIFY)
  ) u_shifter (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .advance(fall),
    .latch  (latch),
    .word_l (word_l),
    .word_r (word_r),
    .slot   (slot),
    .sdata  (i2s_sdata),
    .lrck   (i2s_lrck)
  );

  assign i2s_bclk      = bclk_q;
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_audio_i2s_out.sv
// Bench for audio_i2s_out: an I2S and a left-justified instance share stimulus; frames are
// captured slot by slot at bclk high and compared against hand-computed words.
module tb_audio_i2s_out;

  localparam int H     = 8;
  localparam int FRAME = 64 * H;

  typedef struct {
    logic        m;
    logic [8:0]  sl;
    logic [8:0]  sr;
    logic [15:0] wl;
    logic [15:0] wr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       mute = 1'b0;
  logic [8:0] sound_l = '0;
  logic [8:0] sound_r = '0;
  logic       bclk0, lrck0, sdata0, strobe0;
  logic       bclk1, lrck1, sdata1, strobe1;

  logic [31:0] cap0, cap1, lr0, lr1, bc;
  int          nstb;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        prev_r0;
  vec_t        vt[6];

  audio_i2s_out #(.BCLK_HALF(H), .LEFT_JUSTIFY(0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mute(mute),
    .sound_l(sound_l), .sound_r(sound_r),
    .i2s_bclk(bclk0), .i2s_lrck(lrck0), .i2s_sdata(sdata0), .sample_strobe(strobe0)
  );

  audio_i2s_out #(.BCLK_HALF(H), .LEFT_JUSTIFY(1)) dut_lj (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mute(mute),
    .sound_l(sound_l), .sound_r(sound_r),
    .i2s_bclk(bclk1), .i2s_lrck(lrck1), .i2s_sdata(sdata1), .sample_strobe(strobe1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {24'd0, bclk0, lrck0, sdata0, strobe0, bclk1, lrck1, sdata1, strobe1};
  endfunction

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    while (!strobe0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, " strobe"}, {31'd0, strobe0}, 32'd1);
  endtask

  // Called in the strobe clk (slot 0); returns in the first clk of the following frame.
  task automatic capture(input int drop_slot, input int raise_slot, input int chg_slot,
                         input logic chg_m, input logic [8:0] chg_l, input logic [8:0] chg_r,
                         input logic alt);
    logic p_sd0, p_lr0, p_sd1, p_lr1, p_bc;
    int   k;
    nstb  = 0;
    p_sd0 = sdata0; p_lr0 = lrck0; p_sd1 = sdata1; p_lr1 = lrck1; p_bc = bclk0;
    for (int t = 0; t < FRAME; t++) begin
      if (t % (2 * H) == 0) begin
        k = t / (2 * H);
        if (k == drop_slot)  enable = 1'b0;
        if (k == raise_slot) enable = 1'b1;
        if (k == chg_slot) begin
          mute = chg_m; sound_l = chg_l; sound_r = chg_r;
        end
      end
      if (alt) sound_l = (sound_l == 9'd0) ? 9'd256 : 9'd0;
      @(negedge clk);
      if (strobe0) nstb++;
      if (!strobe0 && (sdata0 != p_sd0 || lrck0 != p_lr0 || sdata1 != p_sd1 || lrck1 != p_lr1))
        check("edge_align", {31'd0, p_bc & ~bclk0}, 32'd1);
      if ((t + 1) % (2 * H) == H) begin
        k = (t + 1) / (2 * H);
        cap0[31-k] = sdata0; cap1[31-k] = sdata1;
        lr0[31-k]  = lrck0;  lr1[31-k]  = lrck1;
        bc[31-k]   = bclk0 & bclk1;
      end
      p_sd0 = sdata0; p_lr0 = lrck0; p_sd1 = sdata1; p_lr1 = lrck1; p_bc = bclk0;
    end
  endtask

  // I2S: slot 0 carries the previous right bit 0, then left MSB..LSB, then right MSB..bit 1.
  task automatic check_frame(input string tag, input logic [15:0] wl, input logic [15:0] wr,
                             input logic pr0, input logic chk_slot0);
    logic [31:0] e0, e1, m;
    e0 = {pr0, wl, wr[15:1]};
    e1 = {wl, wr};
    m  = chk_slot0 ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    $display("frame %s: i2s=%h lj=%h lrck=%h/%h expect l=%h r=%h", tag, cap0, cap1, lr0, lr1, wl, wr);
    check({tag, " i2s_data"}, cap0 & m, e0 & m);
    check({tag, " lj_data"}, cap1, e1);
    check({tag, " i2s_lrck"}, lr0, 32'h0000_FFFF);
    check({tag, " lj_lrck"}, lr1, 32'h0000_FFFF);
    check({tag, " bclk_high"}, bc, 32'hFFFF_FFFF);
  endtask

  initial begin
    vt[0] = '{m: 1'b0, sl: 9'd511, sr: 9'd0,   wl: 16'h7F80, wr: 16'h8000};
    vt[1] = '{m: 1'b0, sl: 9'd256, sr: 9'd256, wl: 16'h0000, wr: 16'h0000};
    vt[2] = '{m: 1'b0, sl: 9'd300, sr: 9'd1,   wl: 16'h1600, wr: 16'h8080};
    vt[3] = '{m: 1'b1, sl: 9'd300, sr: 9'd300, wl: 16'h0000, wr: 16'h0000};
    vt[4] = '{m: 1'b0, sl: 9'd0,   sr: 9'd511, wl: 16'h8000, wr: 16'h7F80};
    vt[5] = '{m: 1'b0, sl: 9'd257, sr: 9'd255, wl: 16'h0080, wr: 16'hFF80};

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outputs", outs(), 32'd0);

    // Table: the frame captured after applying vector i carries vector i-1.
    mute = vt[0].m; sound_l = vt[0].sl; sound_r = vt[0].sr;
    enable  = 1'b1;
    prev_r0 = 1'b0;
    wait_strobe("start");
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        mute = vt[i].m; sound_l = vt[i].sl; sound_r = vt[i].sr;
      end
      capture(-1, -1, -1, 1'b0, 9'd0, 9'd0, 1'b0);
      if (i >= 1) begin
        check_frame($sformatf("vec%0d", i - 1), vt[i-1].wl, vt[i-1].wr, prev_r0, i >= 2);
        prev_r0 = vt[i-1].wr[0];
      end
      check($sformatf("strobes_per_frame%0d", i), nstb, 32'd1);
      wait_strobe($sformatf("frame_len%0d", i));
    end

    // Inputs changed at slot 10 must not disturb the frame in flight.
    capture(-1, -1, 10, 1'b0, 9'd5, 9'd6, 1'b0);
    check_frame("midchange", vt[5].wl, vt[5].wr, vt[5].wr[0], 1'b1);

    // Mute sampled at the latch; releasing it mid-frame only affects the next frame.
    mute = 1'b1; sound_l = 9'd300; sound_r = 9'd300;
    capture(-1, -1, -1, 1'b0, 9'd0, 9'd0, 1'b0);
    capture(-1, -1, 8, 1'b0, 9'd300, 9'd300, 1'b0);
    check_frame("muted", 16'h0000, 16'h0000, 1'b0, 1'b0);
    capture(-1, -1, -1, 1'b0, 9'd0, 9'd0, 1'b0);
    check_frame("unmuted", 16'h1600, 16'h1600, 1'b0, 1'b1);

    // Enable dropped at slot 5: frame completes, then IDLE.
    capture(5, -1, -1, 1'b0, 9'd0, 9'd0, 1'b0);
    check_frame("drop_en", 16'h1600, 16'h1600, 1'b0, 1'b1);
    check("idle_after_drop", outs(), 32'd0);
    repeat (20) @(negedge clk);
    check("idle_hold", outs(), 32'd0);

    // Dropped at slot 5 and re-asserted at slot 30: no gap.
    enable = 1'b1;
    wait_strobe("reenable");
    capture(5, 30, -1, 1'b0, 9'd0, 9'd0, 1'b0);
    check("no_gap_strobe", {31'd0, strobe0}, 32'd1);
    capture(-1, -1, -1, 1'b0, 9'd0, 9'd0, 1'b0);
    check("no_gap_nstb", nstb, 32'd1);

    // Asynchronous reset during slot 9 with bclk high.
    repeat (19 * H + 3) @(negedge clk);
    check("pre_reset_bclk", {31'd0, bclk0}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("restart_strobe", {31'd0, strobe0}, 32'd1);
    check("restart_lrck_bclk", {30'd0, lrck0, bclk0}, 32'd0);
    capture(-1, -1, -1, 1'b0, 9'd0, 9'd0, 1'b0);
    check("restart_lrck_pattern", lr0, 32'h0000_FFFF);

`ifdef AUDIO_I2S_AVG_EN
    mute = 1'b0; sound_l = 9'd0; sound_r = 9'd256;
    capture(-1, -1, -1, 1'b0, 9'd0, 9'd0, 1'b1);
    capture(-1, -1, -1, 1'b0, 9'd0, 9'd0, 1'b0);
    check_frame("average", 16'hC000, 16'h0000, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
